// File: rtl/approx_error_monitor.sv
// Approximate-adder error monitor: compares approx_sum against the exact
// a+b+cin over a run of N samples and reports error count, max and sum ED.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pulse, starts a run (IDLE/DONE only)
//   cfg_num_samples       run length N, latched on accepted start
//   in_valid / in_ready   sample handshake; in_ready only in RUN
//   a, b, cin             adder operands
//   approx_sum            approximate result, MSB is carry-out
//   busy, done            RUN/DRAIN and DONE status
//   err_count             number of mismatching samples
//   max_ed                largest |exact - approx_sum|
//   sum_ed                sum of |exact - approx_sum|
module approx_error_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   cfg_num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [WIDTH:0]     approx_sum,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_count,
    output logic [WIDTH:0]     max_ed,
    output logic [2*WIDTH:0]   sum_ed
);

    localparam int SW = WIDTH + 1;
    localparam int EW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        st_idle,
        st_run,
        st_drain,
        st_done
    } state_t;

    state_t state;
    state_t nxt;

    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] cnt;

    logic          acc;
    logic          start_acc;
    logic [SW-1:0] exact;

    logic          s1_valid;
    logic [SW-1:0] s1_exact;
    logic [SW-1:0] s1_approx;

    logic          s2_valid;
    logic [SW-1:0] s2_ed;
    logic          s2_mis;

    assign acc       = in_valid && in_ready;
    assign start_acc = start && (state == st_idle || state == st_done);
    assign exact     = SW'(a) + SW'(b) + SW'(cin);

    always_comb begin
        nxt = state;
        unique case (state)
            st_idle, st_done: begin
                if (start)
                    nxt = (cfg_num_samples == '0) ? st_done : st_run;
            end
            st_run: begin
                if (acc && cnt == n_lat - CNT_W'(1))
                    nxt = st_drain;
            end
            st_drain: begin
                // last sample has left both stages and updated the stats
                if (!s1_valid && !s2_valid)
                    nxt = st_done;
            end
            default: nxt = st_idle;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state register itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= st_idle;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= nxt;
            in_ready <= (nxt == st_run);
            busy     <= (nxt == st_run) || (nxt == st_drain);
            done     <= (nxt == st_done);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat <= '0;
            cnt   <= '0;
        end else if (start_acc) begin
            n_lat <= cfg_num_samples;
            cnt   <= '0;
        end else if (acc) begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Two-stage datapath; valid bits always advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= acc;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        s1_exact  <= exact;
        s1_approx <= approx_sum;
        s2_ed     <= (s1_exact >= s1_approx) ? (s1_exact - s1_approx)
                                             : (s1_approx - s1_exact);
        s2_mis    <= (s1_exact != s1_approx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (start_acc) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (s2_valid) begin
            if (s2_mis)
                err_count <= err_count + CNT_W'(1);
            if (s2_ed > max_ed)
                max_ed <= s2_ed;
            sum_ed <= sum_ed + EW'(s2_ed);
        end
    end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench for approx_error_monitor: expected statistics are
// modelled per sample, queued per run and popped when done rises.
module tb_approx_error_monitor;

    localparam int W = 16;
    localparam int C = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [C-1:0]   cfg_num_samples;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           cin;
    logic [W:0]     approx_sum;
    logic           busy;
    logic           done;
    logic [C-1:0]   err_count;
    logic [W:0]     max_ed;
    logic [2*W:0]   sum_ed;

    approx_error_monitor #(.WIDTH(W), .CNT_W(C)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_num_samples (cfg_num_samples),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a               (a),
        .b               (b),
        .cin             (cin),
        .approx_sum      (approx_sum),
        .busy            (busy),
        .done            (done),
        .err_count       (err_count),
        .max_ed          (max_ed),
        .sum_ed          (sum_ed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [C-1:0] e;
        logic [W:0]   m;
        logic [2*W:0] s;
    } st_t;

    st_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_total = 0;

    logic [C-1:0] m_err;
    logic [W:0]   m_max;
    logic [2*W:0] m_sum;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready)
            acc_total <= acc_total + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ed_of(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c,
                                         input logic [W:0] ap);
        logic [W:0] ex;
        ex = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return (ex > ap) ? ex - ap : ap - ex;
    endfunction

    task automatic model_clear();
        m_err = '0;
        m_max = '0;
        m_sum = '0;
    endtask

    task automatic model_add(input logic [W:0] ed);
        if (ed != '0)
            m_err = m_err + 1'b1;
        if (ed > m_max)
            m_max = ed;
        m_sum = m_sum + {{W{1'b0}}, ed};
    endtask

    task automatic begin_run(input logic [C-1:0] n);
        start = 1'b1;
        cfg_num_samples = n;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic [W:0] ap,
                        output int acc_cyc);
        a = x;
        b = y;
        cin = c;
        approx_sum = ap;
        in_valid = 1'b1;
        acc_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                model_add(ed_of(x, y, c, ap));
                tick();
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (acc_cyc < 0)
            chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic finish_run(input string tag, input int acc_cyc);
        st_t ex;
        sb.push_back({m_err, m_max, m_sum});
        for (int k = 0; k < 20 && !done; k++)
            tick();
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_lat"}, 64'(cyc - acc_cyc), 64'd3);
        ex = sb.pop_front();
        chk({tag, "_err"}, 64'(err_count), 64'(ex.e));
        chk({tag, "_max"}, 64'(max_ed), 64'(ex.m));
        chk({tag, "_sum"}, 64'(sum_ed), 64'(ex.s));
    endtask

    initial begin
        int t;
        int base;

        rst = 1'b1;
        start = 1'b1;
        cfg_num_samples = 16'd4;
        in_valid = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        approx_sum = 17'h1ffff;
        tick();
        tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_max", 64'(max_ed), 64'd0);
        chk("rst_sum", 64'(sum_ed), 64'd0);
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // four exact samples, in_valid held high
        begin_run(16'd4);
        chk("r4_ready", {63'd0, in_ready}, 64'd1);
        chk("r4_busy", {63'd0, busy}, 64'd1);
        send(16'd1, 16'd2, 1'b0, 17'd3, t);
        send(16'hffff, 16'hffff, 1'b1, 17'h1ffff, t);
        send(16'h1234, 16'h4321, 1'b0, 17'h05555, t);
        send(16'd0, 16'd0, 1'b1, 17'd1, t);
        chk("r4_ready_off", {63'd0, in_ready}, 64'd0);
        chk("r4_drain_busy", {63'd0, busy}, 64'd1);
        finish_run("r4", t);

        // mixed errors
        begin_run(16'd3);
        send(16'h00ff, 16'h0001, 1'b0, 17'h00000, t);
        send(16'h0001, 16'h0001, 1'b1, 17'h00003, t);
        send(16'hffff, 16'h0001, 1'b0, 17'h10003, t);
        finish_run("r3", t);
        chk("r3_err_k", 64'(err_count), 64'd2);
        chk("r3_max_k", 64'(max_ed), 64'h100);
        chk("r3_sum_k", 64'(sum_ed), 64'h103);

        // DONE holds; in_valid outside RUN is ignored
        a = '0;
        b = '0;
        cin = 1'b0;
        approx_sum = 17'h1ffff;
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("hold_ready", {63'd0, in_ready}, 64'd0);
        chk("hold_done", {63'd0, done}, 64'd1);
        chk("hold_err", 64'(err_count), 64'd2);
        chk("hold_sum", 64'(sum_ed), 64'h103);

        // in_valid toggling 1,0,0,1
        begin_run(16'd2);
        base = acc_total;
        chk("tg_ready", {63'd0, in_ready}, 64'd1);
        a = 16'd5;
        b = 16'd5;
        cin = 1'b0;
        approx_sum = 17'h0000f;
        in_valid = 1'b1;
        model_add(ed_of(a, b, cin, approx_sum));
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        a = 16'h8000;
        b = 16'h8000;
        approx_sum = 17'h00000;
        in_valid = 1'b1;
        model_add(ed_of(a, b, cin, approx_sum));
        tick();
        t = cyc;
        in_valid = 1'b0;
        chk("tg_ready_off", {63'd0, in_ready}, 64'd0);
        chk("tg_accepts", 64'(acc_total - base), 64'd2);
        finish_run("tg", t);

        // N = 0 goes straight to DONE
        begin_run(16'd0);
        chk("n0_done", {63'd0, done}, 64'd1);
        chk("n0_busy", {63'd0, busy}, 64'd0);
        chk("n0_ready", {63'd0, in_ready}, 64'd0);
        chk("n0_err", 64'(err_count), 64'd0);
        chk("n0_max", 64'(max_ed), 64'd0);
        chk("n0_sum", 64'(sum_ed), 64'd0);

        // reset mid-run discards everything
        begin_run(16'd5);
        send(16'd1, 16'd1, 1'b0, 17'd0, t);
        send(16'd3, 16'd3, 1'b0, 17'd0, t);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mr_busy", {63'd0, busy}, 64'd0);
        chk("mr_ready", {63'd0, in_ready}, 64'd0);
        chk("mr_err", 64'(err_count), 64'd0);
        chk("mr_sum", 64'(sum_ed), 64'd0);
        begin_run(16'd1);
        send(16'd10, 16'd0, 1'b0, 17'd15, t);
        finish_run("mr", t);
        chk("mr_max_k", 64'(max_ed), 64'd5);

        // start during RUN is ignored
        begin_run(16'd3);
        base = acc_total;
        send(16'd100, 16'd50, 1'b0, 17'd150, t);
        start = 1'b1;
        cfg_num_samples = 16'd1;
        tick();
        start = 1'b0;
        chk("sr_ready", {63'd0, in_ready}, 64'd1);
        chk("sr_busy", {63'd0, busy}, 64'd1);
        send(16'd7, 16'd0, 1'b0, 17'd2, t);
        send(16'd0, 16'd0, 1'b0, 17'd9, t);
        chk("sr_ready_off", {63'd0, in_ready}, 64'd0);
        chk("sr_accepts", 64'(acc_total - base), 64'd3);
        finish_run("sr", t);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/approx_error_monitor.md
APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 Parameter: WIDTH, 16, operand width of the adder under test.
REQ-002 Parameter: CNT_W, 16, width of sample-count configuration and error counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a measurement run.
REQ-006 cfg_num_samples  input  CNT_W  number of samples N in a run, sampled on accepted start.
REQ-007 in_valid  input  1  sample present on a, b, cin, approx_sum.
REQ-008 in_ready  output  1  monitor accepts a sample this cycle.
REQ-009 a, b  input  WIDTH each  adder operands.
REQ-010 cin  input  1  adder carry-in.
REQ-011 approx_sum  input  WIDTH+1  approximate adder result; MSB is carry-out.
REQ-012 busy  output  1  high in RUN or DRAIN.
REQ-013 done  output  1  high while in DONE.
REQ-014 err_count  output  CNT_W  samples with approx_sum != exact sum.
REQ-015 max_ed  output  WIDTH+1  largest error distance |exact - approx_sum| seen.
REQ-016 sum_ed  output  2*WIDTH+1  running sum of error distances; no overflow possible for legal N.

Function
REQ-017 The exact sum SHALL be a + b + cin, computed at WIDTH+1 bits unsigned.
REQ-018 Error distance (ED) SHALL be the unsigned absolute difference of exact sum and approx_sum.
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE or DONE with start=1: clear err_count, max_ed, sum_ed, accepted-count; latch N; go to RUN, or straight to DONE if N=0.
REQ-021 start SHALL be ignored in RUN and DRAIN.
REQ-022 in_ready SHALL be 1 only in RUN; a sample is accepted when in_valid and in_ready are both 1.
REQ-023 In RUN, the accepted-count SHALL increment per accepted sample; on acceptance of sample N, the next state SHALL be DRAIN.
REQ-024 The datapath SHALL be a 2-stage pipeline: stage 1 registers exact sum and approx_sum, stage 2 registers ED and mismatch flag; statistics update one cycle after stage 2.
REQ-025 A sample accepted in cycle t SHALL be reflected in err_count, max_ed, and sum_ed by the end of cycle t+3.
REQ-026 Pipeline valid bits SHALL advance every cycle, with no backpressure inside the pipeline.
REQ-027 In DRAIN, in_ready=0; transition to DONE when all pipeline valid bits are 0 (3 cycles after the last acceptance).
REQ-028 max_ed SHALL update only when the new ED is strictly greater; ties leave it unchanged.
REQ-029 sum_ed SHALL be sized so that N=2^CNT_W-1 samples of maximum ED (2^(WIDTH+1)-1) do not overflow.
REQ-030 Statistic outputs SHALL hold their values in DONE until the next accepted start.
REQ-031 in_valid while not in RUN SHALL have no effect.

Reset
REQ-032 With rst=1: FSM goes to IDLE, pipeline valid bits clear, and the outputs are in_ready=0, busy=0, done=0, err_count=0, max_ed=0, sum_ed=0.
REQ-033 rst SHALL take priority over start and in_valid in the same cycle.
REQ-034 rst asserted mid-run SHALL discard all in-flight samples and partial statistics.

Verification
REQ-035 N=4, four exact samples (approx_sum equals a+b+cin), in_valid held high -> done after 4 accepts plus 3 cycles; err_count=0, max_ed=0, sum_ed=0.
REQ-036 N=3 with samples: a=0x00FF, b=0x0001, cin=0, approx=0x0000; a=1, b=1, cin=1, approx=3; a=0xFFFF, b=1, cin=0, approx=0x10003 -> err_count=2, max_ed=0x100, sum_ed=0x103.
REQ-037 N=2 with in_valid toggling 1,0,0,1 -> exactly 2 accepts; in_ready=0 after the second accept; done asserts 3 cycles later.
REQ-038 start with N=0 -> DONE on the next cycle with all statistics 0; no in_ready pulse.
REQ-039 rst pulsed after 2 of 5 samples, then a new start with N=1 and one ED=5 sample -> err_count=1, max_ed=5, sum_ed=5.
REQ-040 start pulsed during RUN -> ignored; the run completes with the original N.
